jt1943_rom_cache: RTL and testbench

- Sits directly upstream of the 1943 main CPU ROM port.
- Turns the CPU's rom_cs/rom_addr into 32-bit line fetches from the SDRAM controller and returns rom_data/rom_ok.
- Holds a 2-entry, fully-associative line cache with LRU replacement, so tight Z80 loops and straddling opcode fetches avoid SDRAM round trips.
- The main CPU keeps wait_n low until rom_ok rises.

---
 rtl/jt1943_rom_cache_pkg.sv | 11 +
 rtl/jt1943_rom_cache_line.sv | 37 +++
 rtl/jt1943_rom_cache.sv | 90 +++++++++
 tb/tb_jt1943_rom_cache.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_rom_cache_pkg.sv
// Shared constants and FSM encoding for the 1943 main-CPU ROM line cache.
package jt1943_rom_cache_pkg;
  localparam int LINE_BYTES = 4;
  localparam int TAG_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/jt1943_rom_cache_line.sv
// One cache entry: valid/tag/data registers, tag compare, byte select and a write port.
module jt1943_rom_cache_line
  import jt1943_rom_cache_pkg::*;
(
  input  logic             clk,
  input  logic             t80_rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [1:0]       sel,
  output logic             match,
  output logic [7:0]       dout
);
  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [31:0]      data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge t80_rst_n) begin
    if (!t80_rst_n)  valid <= 1'b0;
    else if (clr)    valid <= 1'b0;
    else if (we)     valid <= 1'b1;
  end

  // NOTE: tag/data are left unreset; valid alone decides whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (we) begin
      tag  <= wr_tag;
      data <= wr_data;
    end
  end

  assign match = valid && (tag == rd_tag);
  assign dout  = data[{sel, 3'b000} +: 8];
endmodule

// File: rtl/jt1943_rom_cache.sv
// Two-entry fully-associative LRU line cache between the main CPU ROM port and SDRAM.
module jt1943_rom_cache
  import jt1943_rom_cache_pkg::*;
#(
  parameter logic [21:0] OFFSET = 22'h0,
  parameter int          AW     = 18
) (
  input  logic          clk,
  input  logic          t80_rst_n,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  input  logic          flush,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [31:0]   sdram_data
);
  state_t           state, state_nxt;
  logic             lru;
  logic             poison;
  logic [TAG_W-1:0] fill_tag;
  logic [TAG_W-1:0] cpu_tag;
  logic             m0, m1;
  logic [7:0]       b0, b1;
  logic             hit, miss_start, fill_we;

  assign cpu_tag    = rom_addr[2 +: TAG_W];
  assign hit        = rom_cs && !flush && (m0 || m1);
  assign miss_start = (state == IDLE) && rom_cs && !flush && !hit;
  // Flush on the return cycle discards the line just like an earlier flush did.
  assign fill_we    = (state == WAIT) && data_rdy && !poison && !flush;

  jt1943_rom_cache_line u_line0 (
    .clk(clk), .t80_rst_n(t80_rst_n), .clr(flush), .we(fill_we && !lru),
    .wr_tag(fill_tag), .wr_data(sdram_data), .rd_tag(cpu_tag), .sel(rom_addr[1:0]),
    .match(m0), .dout(b0)
  );

  jt1943_rom_cache_line u_line1 (
    .clk(clk), .t80_rst_n(t80_rst_n), .clr(flush), .we(fill_we && lru),
    .wr_tag(fill_tag), .wr_data(sdram_data), .rd_tag(cpu_tag), .sel(rom_addr[1:0]),
    .match(m1), .dout(b1)
  );

  // Entry 0 wins when a flush race left the same tag in both entries.
  assign rom_ok   = hit;
  assign rom_data = !hit ? 8'h00 : (m0 ? b0 : b1);

  always_ff @(posedge clk or negedge t80_rst_n) begin
    if (!t80_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // NOTE: a default assignment first keeps always_comb from inferring a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_start) state_nxt = REQ;
      REQ:     if (sdram_ack)  state_nxt = WAIT;
      WAIT:    if (data_rdy)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdram_req = (state == REQ);
  end

  always_ff @(posedge clk or negedge t80_rst_n) begin
    if (!t80_rst_n) begin
      sdram_addr <= 22'h0;
      fill_tag   <= '0;
      lru        <= 1'b0;
      poison     <= 1'b0;
    end else begin
      if (miss_start) begin
        fill_tag   <= cpu_tag;
        sdram_addr <= OFFSET + {5'b0, cpu_tag, 1'b0};
      end
      // A fill outranks a hit: the new line becomes most recently used.
      if (fill_we)                       lru <= ~lru;
      else if ((state == IDLE) && hit)   lru <= m0;
      if ((state == WAIT) && data_rdy)   poison <= 1'b0;
      else if ((state != IDLE) && flush) poison <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jt1943_rom_cache.sv
// Scoreboard bench for jt1943_rom_cache: expected fetch addresses and bytes are queued at stimulus time.
module tb_jt1943_rom_cache;
  localparam logic [21:0] OFF = 22'h100000;

  logic        clk = 1'b0;
  logic        t80_rst_n;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        flush;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] sdram_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [21:0] addr_q[$];
  logic [7:0]  byte_q[$];

  jt1943_rom_cache #(.OFFSET(OFF), .AW(18)) dut (
    .clk(clk), .t80_rst_n(t80_rst_n), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .flush(flush), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .sdram_data(sdram_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next fetch request and compare it with the queued address.
  task automatic wait_req(input string tag);
    int waited = 0;
    while (!sdram_req && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!sdram_req) check({tag, "_req_timeout"}, 32'd0, 32'd1);
    check({tag, "_addr"}, sdram_addr, addr_q.pop_front());
  endtask

  task automatic expect_miss(input string tag, input logic [17:0] a, input logic [21:0] exp_addr);
    addr_q.push_back(exp_addr);
    rom_cs   = 1'b1;
    rom_addr = a;
    @(negedge clk);
    check({tag, "_ok"}, rom_ok, 0);
    check({tag, "_data"}, rom_data, 0);
    wait_req(tag);
  endtask

  task automatic ack_and_return(input string tag, input logic [31:0] d);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check({tag, "_req_drop"}, sdram_req, 0);
    data_rdy   = 1'b1;
    sdram_data = d;
    tick();
    data_rdy = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [17:0] a, input logic [7:0] b);
    byte_q.push_back(b);
    rom_cs   = 1'b1;
    rom_addr = a;
    @(negedge clk);
    check({tag, "_ok"}, rom_ok, 1);
    check({tag, "_noreq"}, sdram_req, 0);
    check({tag, "_byte"}, rom_data, byte_q.pop_front());
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq_b [4];
    seq_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    t80_rst_n = 1'b0; rom_cs = 1'b0; rom_addr = '0; flush = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_data = '0;
    #2;
    check("rst_ok", rom_ok, 0);
    check("rst_data", rom_data, 0);
    check("rst_req", sdram_req, 0);
    check("rst_addr", sdram_addr, 0);
    tick(); tick();
    t80_rst_n = 1'b1;
    tick();

    // Cold miss, then the filled line is a hit on the very next cycle.
    expect_miss("cold", 18'h00005, 22'h100002);
    ack_and_return("cold", 32'hDDCCBBAA);
    expect_hit("cold_hit", 18'h00005, 8'hBB);

    for (int i = 0; i < 4; i++) expect_hit("seq", 18'h00004 + 18'(i), seq_b[i]);

    // LRU: lines 1 and 2 cached, line 1 touched last, so line 3 evicts line 2.
    expect_miss("lru_f2", 18'h00008, 22'h100004);
    ack_and_return("lru_f2", 32'h44332211);
    expect_hit("lru_h2", 18'h00008, 8'h11);
    expect_hit("lru_h1", 18'h00004, 8'hAA);
    expect_miss("lru_f3", 18'h0000C, 22'h100006);
    ack_and_return("lru_f3", 32'h88776655);
    expect_hit("lru_keep1", 18'h00004, 8'hAA);
    expect_hit("lru_h3", 18'h0000D, 8'h66);
    expect_miss("lru_evict", 18'h00008, 22'h100004);
    ack_and_return("lru_evict", 32'h44332211);
    expect_hit("lru_refill", 18'h00009, 8'h22);

    // Flush masks a cached line and issues no request.
    rom_cs = 1'b1; rom_addr = 18'h00009; flush = 1'b1;
    @(negedge clk);
    check("flush_ok", rom_ok, 0);
    check("flush_data", rom_data, 0);
    tick();
    check("flush_noreq", sdram_req, 0);
    flush = 1'b0;

    // Flush during WAIT poisons the returning line; a fresh fetch follows.
    expect_miss("race", 18'h00040, 22'h100020);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("race_flush_ok", rom_ok, 0);
    tick();
    flush = 1'b0; data_rdy = 1'b1; sdram_data = 32'hA3A2A1A0;
    tick();
    data_rdy = 1'b0;
    @(negedge clk);
    check("race_discard", rom_ok, 0);
    addr_q.push_back(22'h100020);
    wait_req("race_retry");
    ack_and_return("race_retry", 32'hA3A2A1A0);
    expect_hit("race_hit", 18'h00041, 8'hA1);

    // rom_cs abandons the fetch in REQ; the line still gets installed.
    expect_miss("aband", 18'h00100, 22'h100080);
    tick();
    rom_cs = 1'b0;
    @(negedge clk);
    check("aband_hold_req", sdram_req, 1);
    check("aband_hold_addr", sdram_addr, 22'h100080);
    ack_and_return("aband", 32'hB3B2B1B0);
    tick();
    @(negedge clk);
    check("aband_cs_low_ok", rom_ok, 0);
    tick();
    expect_hit("aband_hit", 18'h00102, 8'hB2);

    // Asynchronous reset in WAIT, then a stale data_rdy must change nothing.
    expect_miss("rst", 18'h00200, 22'h100100);
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rom_addr = 18'h00102;
    @(negedge clk);
    check("rst_wait_hit", rom_ok, 1);
    #1 t80_rst_n = 1'b0;
    #1;
    check("rst_async_req", sdram_req, 0);
    check("rst_async_ok", rom_ok, 0);
    check("rst_async_addr", sdram_addr, 0);
    rom_cs = 1'b0;
    tick();
    t80_rst_n = 1'b1;
    tick();
    data_rdy = 1'b1; sdram_data = 32'hFFEEDDCC;
    tick();
    data_rdy = 1'b0;
    @(negedge clk);
    check("rst_late_rdy_req", sdram_req, 0);
    expect_miss("rst_retry", 18'h00200, 22'h100100);
    ack_and_return("rst_retry", 32'h07060504);
    expect_hit("rst_hit", 18'h00203, 8'h07);

    check("sb_drain", 32'(addr_q.size() + byte_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
